mole_autoplayer: RTL and testbench
==================================

MOLE_AUTOPLAYER -- requirements
Module: mole_autoplayer

Interface
REQ-001 Parameter REACT_CYCLES, default 1000, sets the reaction delay in clocks between mole acquisition and button press (1 ms at 1 MHz).
REQ-002 Parameter PRESS_CYCLES, default 20000, sets the button hold time in clocks.
REQ-003 Parameter RELEASE_CYCLES, default 5000, sets the minimum button-low time after each press.
REQ-004 Port clk, input, 1, the single clock; every flop is clocked on the rising edge.
REQ-005 Port rst, input, 1, reset: asynchronous, active-high.
REQ-006 Port seg, input, 8, the game's 7-segment output; [6:0]=gfedcba, [7]=dp (ignored).
REQ-007 Port game_end, input, 1, the game-over level from the game timer.
REQ-008 Port enable, input, 1, autoplay enable.
REQ-009 Port btn, output, 8, one-hot button drive into the game's button inputs.
REQ-010 Port press_count, output, 8, number of presses issued; saturates at 255.
REQ-011 Port busy, output, 1, high in every state except IDLE and DONE.

Function
REQ-012 seg[6:0] SHALL pass through a 2-flop synchronizer, then decode as follows.
- 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7.
- 0x00=blank.
- Any other pattern is invalid and treated as blank.
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT, PRESS, RELEASE and DONE.
REQ-014 IDLE->WAIT SHALL occur when enable=1 and the same valid index is decoded on 2 consecutive synchronized samples; that index is latched as tgt.
REQ-015 In WAIT, a countdown SHALL run for REACT_CYCLES clocks, then go to PRESS. If the decoded index differs from tgt during the countdown, the FSM SHALL return to IDLE with no press.
REQ-016 In PRESS, btn SHALL equal 1<<tgt for exactly PRESS_CYCLES clocks, then go to RELEASE. A seg change during PRESS SHALL NOT abort the press.
REQ-017 In RELEASE, btn SHALL be 0 for at least RELEASE_CYCLES clocks. The FSM SHALL then go to IDLE only once the decoded index is not equal to tgt; if the same mole stays displayed, the FSM remains in RELEASE.
REQ-018 press_count SHALL increment on each WAIT->PRESS transition and SHALL hold at 255.
REQ-019 btn SHALL rise exactly REACT_CYCLES+3 clocks after a stable seg change.
REQ-020 btn SHALL be zero in every state other than PRESS, and SHALL never have more than one bit set.
REQ-021 game_end=1 SHALL force DONE on the next edge from any state, with btn=0. game_end wins over all simultaneous events.
REQ-022 DONE SHALL be left only by reset.
REQ-023 enable=0 SHALL force IDLE on the next edge from WAIT, PRESS or RELEASE, with btn=0; press_count is held.
REQ-024 The delay counter SHALL be 20 bits wide. Parameter values of 0 SHALL be treated as 1.

Reset
REQ-025 rst=1 SHALL asynchronously clear state to IDLE and clear btn, press_count, busy, tgt, the counter and the synchronizer flops to 0.
REQ-026 Reset asserted mid-PRESS SHALL drop btn in the same cycle, with no clock edge required.

Configuration
REQ-027 When macro MOLE_AUTOPLAYER_MISS_INJECT_EN is defined, the following SHALL be compiled in.
- An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0xA5 on reset) advances every clock.
- On WAIT->PRESS, if lfsr[2:0]==0, the FSM SHALL press index (tgt+1) mod 8 instead of tgt.
REQ-028 Without the macro, no LFSR SHALL exist and the FSM SHALL always press tgt.

Structure
REQ-029 Package mole_autoplayer_pkg SHALL hold the state enum, the eight glyph constants, GLYPH_BLANK, the LFSR seed and the LFSR taps.
REQ-030 The glyph decode SHALL be a combinational sub-module mole_glyph_decode, taking seg[6:0] and giving valid and idx[2:0].

Verification
REQ-031 The bench SHALL run with REACT=4, PRESS=3, RELEASE=2, and SHALL cover these scenarios.
- seg 0x00->0x66 at cycle 0 -> btn=0x10 during cycles 7-9, press_count=1, busy falls after seg returns to 0x00.
- seg 0x5B then 0x6D at WAIT cycle 2 -> no press, re-acquire, btn=0x20.
- Mole 3 (0x4F) held 50 cycles -> exactly one press (btn=0x08), FSM stays in RELEASE.
- game_end pulsed during PRESS -> btn=0x00 next edge, busy=0, no further presses on new glyphs.
- seg 0x7F (invalid) and enable=0 with 0x06 -> btn stays 0x00.
- 300 mole cycles -> press_count=255.
- With MOLE_AUTOPLAYER_MISS_INJECT_EN defined -> the 0x00 -> 0x06 sequence shows btn=0x04 on the press whose LFSR low bits are 0.

Source files
------------

// File: rtl/mole_autoplayer_pkg.sv
// Shared types and constants for the whack-a-mole autoplayer: FSM states,
// 7-segment glyph codes, delay-counter width and miss-injection LFSR settings.
package mole_autoplayer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    PRESS   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Segment order is gfedcba.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int CNT_W = 20;

  // A phase of N clocks loads N-1 and ends on the clock where the count is 0;
  // a requested length of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] cycles_to_load(input int cycles);
    return (cycles <= 1) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mole_glyph_decode.sv
// Combinational 7-segment glyph decoder: maps a gfedcba pattern to a mole
// index 0-7; blank and unrecognised patterns report valid_o = 0.
module mole_glyph_decode (
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);
  import mole_autoplayer_pkg::*;

  always_comb begin
    valid_o = 1'b1;
    idx_o   = 3'd0;
    case (seg_i)
      GLYPH_0: idx_o = 3'd0;
      GLYPH_1: idx_o = 3'd1;
      GLYPH_2: idx_o = 3'd2;
      GLYPH_3: idx_o = 3'd3;
      GLYPH_4: idx_o = 3'd4;
      GLYPH_5: idx_o = 3'd5;
      GLYPH_6: idx_o = 3'd6;
      GLYPH_7: idx_o = 3'd7;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mole_autoplayer.sv
// Whack-a-mole autoplayer: watches the game's 7-segment output and presses
// the matching button. Define MOLE_AUTOPLAYER_MISS_INJECT_EN for LFSR miss injection.
module mole_autoplayer #(
  parameter int REACT_CYCLES   = 1000,
  parameter int PRESS_CYCLES   = 20000,
  parameter int RELEASE_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic       game_end,
  input  logic       enable,
  output logic [7:0] btn,
  output logic [7:0] press_count,
  output logic       busy
);
  import mole_autoplayer_pkg::*;

  localparam logic [CNT_W-1:0] REACT_LOAD   = cycles_to_load(REACT_CYCLES);
  localparam logic [CNT_W-1:0] PRESS_LOAD   = cycles_to_load(PRESS_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = cycles_to_load(RELEASE_CYCLES);

  logic             unused_dp;
  logic [6:0]       seg_s1_q, seg_s2_q;
  state_e           state_q, state_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       press_idx_q, press_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       press_count_q, press_count_d;
  logic             valid_s1, valid_s2;
  logic [2:0]       idx_s1, idx_s2;
  logic             press_miss;
  logic             tgt_lost;

  assign unused_dp = seg[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
    end else begin
      seg_s1_q <= seg[6:0];
      seg_s2_q <= seg_s1_q;
    end
  end

  // Acquisition compares the two synchronizer stages so that the press lands
  // REACT_CYCLES+3 clocks after the glyph settles.
  mole_glyph_decode u_dec_s1 (.seg_i(seg_s1_q), .valid_o(valid_s1), .idx_o(idx_s1));
  mole_glyph_decode u_dec_s2 (.seg_i(seg_s2_q), .valid_o(valid_s2), .idx_o(idx_s2));

`ifdef MOLE_AUTOPLAYER_MISS_INJECT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign press_miss = (lfsr_q[2:0] == 3'd0);
`else
  assign press_miss = 1'b0;
`endif

  assign tgt_lost = !valid_s2 || (idx_s2 != tgt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      press_idx_q   <= '0;
      cnt_q         <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      press_idx_q   <= press_idx_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    press_idx_d   = press_idx_q;
    cnt_d         = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    press_count_d = press_count_q;
    if (game_end) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && valid_s1 && valid_s2 && (idx_s1 == idx_s2)) begin
            state_d = WAIT;
            tgt_d   = idx_s2;
            cnt_d   = REACT_LOAD;
          end
        end
        WAIT: begin
          if (!enable || tgt_lost) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d     = PRESS;
            cnt_d       = PRESS_LOAD;
            press_idx_d = tgt_q + {2'b00, press_miss};
            if (press_count_q != 8'hFF) press_count_d = press_count_q + 8'd1;
          end
        end
        PRESS: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = RELEASE;
            cnt_d   = RELEASE_LOAD;
          end
        end
        RELEASE: begin
          // Hold off until the pressed mole has gone, so one mole gets one press.
          if (!enable || ((cnt_q == '0) && tgt_lost)) state_d = IDLE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign btn         = (state_q == PRESS) ? (8'd1 << press_idx_q) : 8'd0;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign press_count = press_count_q;

endmodule

// File: tb/tb_mole_autoplayer.sv
// Directed testbench for mole_autoplayer with REACT=4, PRESS=3, RELEASE=2;
// the miss-injection scenario builds only with MOLE_AUTOPLAYER_MISS_INJECT_EN.
module tb_mole_autoplayer;

  logic       clk;
  logic       rst;
  logic [7:0] seg;
  logic       gameEnd;
  logic       enable;
  logic [7:0] btn;
  logic [7:0] pressCount;
  logic       busy;

  int compared;
  int mismatched;

  mole_autoplayer #(
    .REACT_CYCLES(4),
    .PRESS_CYCLES(3),
    .RELEASE_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg(seg),
    .game_end(gameEnd),
    .enable(enable),
    .btn(btn),
    .press_count(pressCount),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MOLE_AUTOPLAYER_MISS_INJECT_EN
  logic [7:0] modelLfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) modelLfsr <= 8'hA5;
    else     modelLfsr <= {modelLfsr[6:0], modelLfsr[7] ^ modelLfsr[5] ^ modelLfsr[4] ^ modelLfsr[3]};
  end
`endif

  // Every sample and input change happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at "cycle 0": reset just released, inputs idle, enable on.
  task automatic doReset();
    rst     = 1'b1;
    seg     = 8'h00;
    gameEnd = 1'b0;
    enable  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    seg     = 8'h66;
    gameEnd = 1'b0;
    enable  = 1'b1;
    tick();
    tick();
    compared++;
    if (btn !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_btn actual=%h required=%h", btn, 8'h00);
    end
    compared++;
    if (pressCount !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_press_count actual=%0d required=0", pressCount);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy actual=%b required=0", busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_press();
    logic [7:0] expBtn;
    logic       expBusy;
    logic [7:0] expCnt;
    doReset();
    seg = 8'h66;
    for (int c = 1; c <= 16; c++) begin
      tick();
      expBtn  = (c >= 7 && c <= 9) ? 8'h10 : 8'h00;
      expBusy = (c >= 3 && c <= 14);
      expCnt  = (c >= 7) ? 8'd1 : 8'd0;
      compared++;
      if (btn !== expBtn) begin
        mismatched++;
        $display("[TB] FAIL basic_btn cycle=%0d actual=%h required=%h", c, btn, expBtn);
      end
      compared++;
      if (busy !== expBusy) begin
        mismatched++;
        $display("[TB] FAIL basic_busy cycle=%0d actual=%b required=%b", c, busy, expBusy);
      end
      compared++;
      if (pressCount !== expCnt) begin
        mismatched++;
        $display("[TB] FAIL basic_count cycle=%0d actual=%0d required=%0d", c, pressCount, expCnt);
      end
      if (c == 12) seg = 8'h00;
    end
  endtask

  task automatic test_wait_abort();
    logic [7:0] expBtn;
    logic       expBusy;
    doReset();
    seg = 8'h5B;
    for (int c = 1; c <= 16; c++) begin
      tick();
      expBtn  = (c >= 12 && c <= 14) ? 8'h20 : 8'h00;
      expBusy = (c >= 3 && c <= 6) || (c >= 8);
      compared++;
      if (btn !== expBtn) begin
        mismatched++;
        $display("[TB] FAIL abort_btn cycle=%0d actual=%h required=%h", c, btn, expBtn);
      end
      compared++;
      if (busy !== expBusy) begin
        mismatched++;
        $display("[TB] FAIL abort_busy cycle=%0d actual=%b required=%b", c, busy, expBusy);
      end
      if (c == 4) seg = 8'h6D;
    end
    compared++;
    if (pressCount !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL abort_count actual=%0d required=1", pressCount);
    end
  endtask

  task automatic test_hold_mole();
    int pressCycles;
    int wrongBtn;
    doReset();
    seg = 8'h4F;
    pressCycles = 0;
    wrongBtn    = 0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (btn !== 8'h00) pressCycles++;
      if (btn !== 8'h00 && btn !== 8'h08) wrongBtn++;
    end
    compared++;
    if (pressCycles != 3) begin
      mismatched++;
      $display("[TB] FAIL hold_press_cycles actual=%0d required=3", pressCycles);
    end
    compared++;
    if (wrongBtn != 0) begin
      mismatched++;
      $display("[TB] FAIL hold_btn_value wrong_cycles=%0d required=0", wrongBtn);
    end
    compared++;
    if (pressCount !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL hold_count actual=%0d required=1", pressCount);
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_busy_in_release actual=%b required=1", busy);
    end
  endtask

  task automatic test_game_end();
    int activeCycles;
    doReset();
    seg = 8'h66;
    repeat (8) tick();
    compared++;
    if (btn !== 8'h10) begin
      mismatched++;
      $display("[TB] FAIL gameend_pre_btn actual=%h required=%h", btn, 8'h10);
    end
    gameEnd = 1'b1;
    tick();
    compared++;
    if (btn !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL gameend_btn actual=%h required=%h", btn, 8'h00);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL gameend_busy actual=%b required=0", busy);
    end
    gameEnd = 1'b0;
    seg = 8'h00;
    repeat (4) tick();
    seg = 8'h06;
    activeCycles = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (btn !== 8'h00 || busy !== 1'b0) activeCycles++;
    end
    compared++;
    if (activeCycles != 0) begin
      mismatched++;
      $display("[TB] FAIL gameend_stays_done active_cycles=%0d required=0", activeCycles);
    end
    compared++;
    if (pressCount !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL gameend_count actual=%0d required=1", pressCount);
    end
  endtask

  task automatic test_invalid_and_enable();
    int activeCycles;
    doReset();
    seg = 8'h7F;
    activeCycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn !== 8'h00 || busy !== 1'b0) activeCycles++;
    end
    compared++;
    if (activeCycles != 0) begin
      mismatched++;
      $display("[TB] FAIL invalid_glyph active_cycles=%0d required=0", activeCycles);
    end
    enable = 1'b0;
    seg = 8'h06;
    activeCycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn !== 8'h00 || busy !== 1'b0) activeCycles++;
    end
    compared++;
    if (activeCycles != 0) begin
      mismatched++;
      $display("[TB] FAIL enable_low active_cycles=%0d required=0", activeCycles);
    end

    doReset();
    seg = 8'h06;
    repeat (8) tick();
    compared++;
    if (btn !== 8'h02) begin
      mismatched++;
      $display("[TB] FAIL enable_pre_btn actual=%h required=%h", btn, 8'h02);
    end
    enable = 1'b0;
    tick();
    compared++;
    if (btn !== 8'h00 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL enable_drop btn=%h busy=%b required btn=00 busy=0", btn, busy);
    end
    repeat (10) tick();
    compared++;
    if (pressCount !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL enable_drop_count actual=%0d required=1", pressCount);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    seg = 8'h4F;
    repeat (8) tick();
    compared++;
    if (btn !== 8'h08) begin
      mismatched++;
      $display("[TB] FAIL async_pre_btn actual=%h required=%h", btn, 8'h08);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (btn !== 8'h00 || busy !== 1'b0 || pressCount !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL async_reset btn=%h busy=%b count=%0d required 00/0/0", btn, busy, pressCount);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back_saturate();
    doReset();
    for (int i = 0; i < 300; i++) begin
      seg = 8'h06;
      repeat (12) tick();
      seg = 8'h00;
      repeat (6) tick();
      if (i == 9) begin
        compared++;
        if (pressCount !== 8'd10) begin
          mismatched++;
          $display("[TB] FAIL b2b_count_10 actual=%0d required=10", pressCount);
        end
      end
    end
    compared++;
    if (pressCount !== 8'd255) begin
      mismatched++;
      $display("[TB] FAIL b2b_saturate actual=%0d required=255", pressCount);
    end
  endtask

`ifdef MOLE_AUTOPLAYER_MISS_INJECT_EN
  task automatic test_miss_inject();
    logic [2:0] lowBits;
    logic [7:0] expBtn;
    doReset();
    for (int i = 0; i < 24; i++) begin
      seg = 8'h06;
      repeat (6) tick();
      lowBits = modelLfsr[2:0];
      tick();
      expBtn = (lowBits == 3'd0) ? 8'h04 : 8'h02;
      compared++;
      if (btn !== expBtn) begin
        mismatched++;
        $display("[TB] FAIL miss_inject press=%0d actual=%h required=%h", i, btn, expBtn);
      end
      repeat (5) tick();
      seg = 8'h00;
      repeat (6) tick();
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    seg        = 8'h00;
    gameEnd    = 1'b0;
    enable     = 1'b0;
    test_reset();
    test_basic_press();
    test_wait_abort();
    test_hold_mole();
    test_game_end();
    test_invalid_and_enable();
    test_async_reset();
    test_back_to_back_saturate();
`ifdef MOLE_AUTOPLAYER_MISS_INJECT_EN
    test_miss_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
